// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM with byte lanes, 1/2-cycle read latency, RDW mode and collision flag.
// Optional power-on clear sequencer is compiled in with `define DPRAM_CLEAR_EN.
module dual_port_ram #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_SPACE   = 16,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [ADDR_SPACE-1:0]            a_address,
  input  logic [DATA_WIDTH-1:0]            a_data,
  input  logic                             a_wren,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_byteena,
  input  logic                             a_rden,
  output logic [DATA_WIDTH-1:0]            a_q,
  output logic                             a_qvalid,
  input  logic [ADDR_SPACE-1:0]            b_address,
  input  logic [DATA_WIDTH-1:0]            b_data,
  input  logic                             b_wren,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_byteena,
  input  logic                             b_rden,
  output logic [DATA_WIDTH-1:0]            b_q,
  output logic                             b_qvalid,
  output logic                             collision,
  output logic                             busy
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_SPACE;

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("dual_port_ram: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("dual_port_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
  endgenerate

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         lanes
  );
    merge_lanes = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lanes[i]) begin
        merge_lanes[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  endfunction

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  hold_s;
  logic                  clr_we_s;
  logic [ADDR_SPACE-1:0] clr_addr_s;
  logic                  ext_ok_s;
  logic [NB-1:0]         a_lane_s;
  logic [NB-1:0]         b_lane_s;
  logic [NB-1:0]         wa_lane_s;
  logic [ADDR_SPACE-1:0] wa_addr_s;
  logic [DATA_WIDTH-1:0] wa_data_s;
  logic                  a_rd_s;
  logic                  b_rd_s;
  logic [DATA_WIDTH-1:0] a_rdata_s;
  logic [DATA_WIDTH-1:0] b_rdata_s;

  logic [DATA_WIDTH-1:0] a_q1_r;
  logic [DATA_WIDTH-1:0] b_q1_r;
  logic                  a_v1_r;
  logic                  b_v1_r;
  logic                  collision_r;

`ifdef DPRAM_CLEAR_EN
  logic                  busy_r;
  logic                  start_r;
  logic [ADDR_SPACE-1:0] clr_cnt_r;

  // Clear sequencer: armed by reset, walks every address once after reset falls.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r    <= 1'b0;
      start_r   <= 1'b1;
      clr_cnt_r <= {ADDR_SPACE{1'b0}};
    end else if (start_r) begin
      busy_r    <= 1'b1;
      start_r   <= 1'b0;
      clr_cnt_r <= {ADDR_SPACE{1'b0}};
    end else if (busy_r) begin
      clr_cnt_r <= clr_cnt_r + ADDR_SPACE'(1);
      if (clr_cnt_r == {ADDR_SPACE{1'b1}}) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= 1'b1;
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign hold_s     = busy_r | start_r;
  assign clr_we_s   = busy_r & ~reset;
  assign clr_addr_s = clr_cnt_r;
  assign busy       = busy_r;
`else
  assign hold_s     = 1'b0;
  assign clr_we_s   = 1'b0;
  assign clr_addr_s = {ADDR_SPACE{1'b0}};
  assign busy       = 1'b0;
`endif

  assign ext_ok_s  = ~reset & ~hold_s;
  assign a_lane_s  = (ext_ok_s & a_wren) ? a_byteena : {NB{1'b0}};
  assign b_lane_s  = (ext_ok_s & b_wren) ? b_byteena : {NB{1'b0}};
  assign a_rd_s    = ext_ok_s & a_rden;
  assign b_rd_s    = ext_ok_s & b_rden;

  assign wa_lane_s = clr_we_s ? {NB{1'b1}} : a_lane_s;
  assign wa_addr_s = clr_we_s ? clr_addr_s : a_address;
  assign wa_data_s = clr_we_s ? {DATA_WIDTH{1'b0}} : a_data;

  // Own-port merge only; the other port's same-cycle write is never visible.
  assign a_rdata_s = (RDW_MODE == 1) ? merge_lanes(mem[a_address], a_data, a_lane_s) : mem[a_address];
  assign b_rdata_s = (RDW_MODE == 1) ? merge_lanes(mem[b_address], b_data, b_lane_s) : mem[b_address];

  // Memory array; port A is written last so it wins any lane both ports enable.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++) begin
      if (b_lane_s[i]) begin
        mem[b_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (wa_lane_s[i]) begin
        mem[wa_addr_s][i*BYTE_WIDTH +: BYTE_WIDTH] <= wa_data_s[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // First read stage and collision flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q1_r      <= {DATA_WIDTH{1'b0}};
      b_q1_r      <= {DATA_WIDTH{1'b0}};
      a_v1_r      <= 1'b0;
      b_v1_r      <= 1'b0;
      collision_r <= 1'b0;
    end else begin
      a_v1_r      <= a_rd_s;
      b_v1_r      <= b_rd_s;
      collision_r <= (a_address == b_address) && (|(a_lane_s & b_lane_s));
      if (a_rd_s) begin
        a_q1_r <= a_rdata_s;
      end
      if (b_rd_s) begin
        b_q1_r <= b_rdata_s;
      end
    end
  end

  assign collision = collision_r;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] a_q2_r;
      logic [DATA_WIDTH-1:0] b_q2_r;
      logic                  a_v2_r;
      logic                  b_v2_r;

      // Extra output register stage.
      always_ff @(posedge clock) begin
        if (reset) begin
          a_q2_r <= {DATA_WIDTH{1'b0}};
          b_q2_r <= {DATA_WIDTH{1'b0}};
          a_v2_r <= 1'b0;
          b_v2_r <= 1'b0;
        end else begin
          a_v2_r <= a_v1_r;
          b_v2_r <= b_v1_r;
          if (a_v1_r) begin
            a_q2_r <= a_q1_r;
          end
          if (b_v1_r) begin
            b_q2_r <= b_q1_r;
          end
        end
      end

      assign a_q      = a_q2_r;
      assign a_qvalid = a_v2_r;
      assign b_q      = b_q2_r;
      assign b_qvalid = b_v2_r;
    end else begin : g_lat1
      assign a_q      = a_q1_r;
      assign a_qvalid = a_v1_r;
      assign b_q      = b_q1_r;
      assign b_qvalid = b_v1_r;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram: a latency-1/read-first instance driven by a vector table,
// plus a latency-2/write-first instance sharing the same stimulus for the pipeline corner cases.
module tb_dual_port_ram;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  a_address, b_address;
  logic [15:0] a_data, b_data;
  logic        a_wren, b_wren, a_rden, b_rden;
  logic [1:0]  a_byteena, b_byteena;
  logic [15:0] a_q, b_q, a_q2, b_q2;
  logic        a_qvalid, b_qvalid, a_qvalid2, b_qvalid2;
  logic        collision, collision2, busy, busy2;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dual_port_ram #(.DATA_WIDTH(16), .ADDR_SPACE(4), .BYTE_WIDTH(8), .READ_LATENCY(1), .RDW_MODE(0)) dut (
    .clock(clock), .reset(reset),
    .a_address(a_address), .a_data(a_data), .a_wren(a_wren), .a_byteena(a_byteena), .a_rden(a_rden),
    .a_q(a_q), .a_qvalid(a_qvalid),
    .b_address(b_address), .b_data(b_data), .b_wren(b_wren), .b_byteena(b_byteena), .b_rden(b_rden),
    .b_q(b_q), .b_qvalid(b_qvalid),
    .collision(collision), .busy(busy)
  );

  dual_port_ram #(.DATA_WIDTH(16), .ADDR_SPACE(4), .BYTE_WIDTH(8), .READ_LATENCY(2), .RDW_MODE(1)) dut2 (
    .clock(clock), .reset(reset),
    .a_address(a_address), .a_data(a_data), .a_wren(a_wren), .a_byteena(a_byteena), .a_rden(a_rden),
    .a_q(a_q2), .a_qvalid(a_qvalid2),
    .b_address(b_address), .b_data(b_data), .b_wren(b_wren), .b_byteena(b_byteena), .b_rden(b_rden),
    .b_q(b_q2), .b_qvalid(b_qvalid2),
    .collision(collision2), .busy(busy2)
  );

  typedef struct {
    logic [3:0]  aa; logic [15:0] ad; logic aw; logic [1:0] abe; logic ar;
    logic [3:0]  ba; logic [15:0] bd; logic bw; logic [1:0] bbe; logic br;
    logic [15:0] eaq; logic eav; logic [15:0] ebq; logic ebv; logic ecol;
    string       name;
  } vec_t;

  vec_t vecs[21];

`ifdef DPRAM_CLEAR_EN
  localparam logic [15:0] POST_RST_1 = 16'h0000;
`else
  localparam logic [15:0] POST_RST_1 = 16'h0101;
`endif

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    a_address = 4'd0; a_data = 16'h0000; a_wren = 1'b0; a_byteena = 2'b00; a_rden = 1'b0;
    b_address = 4'd0; b_data = 16'h0000; b_wren = 1'b0; b_byteena = 2'b00; b_rden = 1'b0;
  endtask

  task automatic wait_idle();
    step();
    for (int i = 0; i < 40 && (busy || busy2); i++) step();
    chk("busy_idle", {15'd0, busy}, 16'h0000);
    chk("busy2_idle", {15'd0, busy2}, 16'h0000);
  endtask

`ifdef DPRAM_CLEAR_EN
  task automatic count_busy(input int limit, output int n, output int qv_seen);
    n = 0;
    qv_seen = 0;
    while (busy && n < limit) begin
      n++;
      if (a_qvalid || a_qvalid2) qv_seen++;
      step();
    end
  endtask
`endif

  initial begin
    vecs[0]  = '{4'd3, 16'hBEEF, 1'b1, 2'b11, 1'b0,  4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "a_wr3"};
    vecs[1]  = '{4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  4'd3, 16'h0000, 1'b0, 2'b00, 1'b1,  16'h0000, 1'b0, 16'hBEEF, 1'b1, 1'b0, "b_rd3"};
    vecs[2]  = '{4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  16'h0000, 1'b0, 16'hBEEF, 1'b0, 1'b0, "hold"};
    vecs[3]  = '{4'd5, 16'h1234, 1'b1, 2'b11, 1'b0,  4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  16'h0000, 1'b0, 16'hBEEF, 1'b0, 1'b0, "a_wr5"};
    vecs[4]  = '{4'd5, 16'hAB00, 1'b1, 2'b10, 1'b0,  4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  16'h0000, 1'b0, 16'hBEEF, 1'b0, 1'b0, "a_wr5_hi"};
    vecs[5]  = '{4'd5, 16'h0000, 1'b0, 2'b00, 1'b1,  4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  16'hAB34, 1'b1, 16'hBEEF, 1'b0, 1'b0, "a_rd5"};
    vecs[6]  = '{4'd5, 16'h1234, 1'b1, 2'b11, 1'b0,  4'd5, 16'h0000, 1'b0, 2'b00, 1'b1,  16'hAB34, 1'b0, 16'hAB34, 1'b1, 1'b0, "cross_rdw"};
    vecs[7]  = '{4'd5, 16'hCD00, 1'b1, 2'b10, 1'b1,  4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  16'h1234, 1'b1, 16'hAB34, 1'b0, 1'b0, "a_rdw_old"};
    vecs[8]  = '{4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  4'd5, 16'h0000, 1'b0, 2'b00, 1'b1,  16'h1234, 1'b0, 16'hCD34, 1'b1, 1'b0, "b_rd5"};
    vecs[9]  = '{4'd7, 16'h1111, 1'b1, 2'b11, 1'b0,  4'd7, 16'h2222, 1'b1, 2'b01, 1'b0,  16'h1234, 1'b0, 16'hCD34, 1'b0, 1'b1, "coll_ovl"};
    vecs[10] = '{4'd7, 16'h0000, 1'b0, 2'b00, 1'b1,  4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  16'h1111, 1'b1, 16'hCD34, 1'b0, 1'b0, "a_rd7"};
    vecs[11] = '{4'd7, 16'h1111, 1'b1, 2'b10, 1'b0,  4'd7, 16'h2222, 1'b1, 2'b01, 1'b0,  16'h1111, 1'b0, 16'hCD34, 1'b0, 1'b0, "coll_none"};
    vecs[12] = '{4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  4'd7, 16'h0000, 1'b0, 2'b00, 1'b1,  16'h1111, 1'b0, 16'h1122, 1'b1, 1'b0, "b_rd7"};
    vecs[13] = '{4'd2, 16'h00FF, 1'b1, 2'b11, 1'b0,  4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  16'h1111, 1'b0, 16'h1122, 1'b0, 1'b0, "a_wr2"};
    vecs[14] = '{4'd2, 16'hFFFF, 1'b1, 2'b00, 1'b0,  4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  16'h1111, 1'b0, 16'h1122, 1'b0, 1'b0, "a_be0"};
    vecs[15] = '{4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  4'd2, 16'h1200, 1'b1, 2'b10, 1'b1,  16'h1111, 1'b0, 16'h00FF, 1'b1, 1'b0, "b_rdw_old"};
    vecs[16] = '{4'd2, 16'h0000, 1'b0, 2'b00, 1'b1,  4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  16'h12FF, 1'b1, 16'h00FF, 1'b0, 1'b0, "a_rd2"};
    vecs[17] = '{4'd9, 16'hAAAA, 1'b1, 2'b11, 1'b0,  4'd9, 16'hBBBB, 1'b1, 2'b11, 1'b0,  16'h12FF, 1'b0, 16'h00FF, 1'b0, 1'b1, "coll_full"};
    vecs[18] = '{4'd3, 16'h0000, 1'b0, 2'b00, 1'b1,  4'd9, 16'h0000, 1'b0, 2'b00, 1'b1,  16'hBEEF, 1'b1, 16'hAAAA, 1'b1, 1'b0, "dual_rd"};
    vecs[19] = '{4'd7, 16'h0000, 1'b0, 2'b00, 1'b1,  4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  16'h1122, 1'b1, 16'hAAAA, 1'b0, 1'b0, "b2b_1"};
    vecs[20] = '{4'd5, 16'h0000, 1'b0, 2'b00, 1'b1,  4'd0, 16'h0000, 1'b0, 2'b00, 1'b0,  16'hCD34, 1'b1, 16'hAAAA, 1'b0, 1'b0, "b2b_2"};

    idle_in();
    reset = 1'b1;
    repeat (3) step();
    chk("rst_aq", a_q, 16'h0000);
    chk("rst_aqv", {15'd0, a_qvalid}, 16'h0000);
    chk("rst_bq", b_q, 16'h0000);
    chk("rst_bqv", {15'd0, b_qvalid}, 16'h0000);
    chk("rst_col", {15'd0, collision}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    chk("rst_aq2", a_q2, 16'h0000);
    reset = 1'b0;
    wait_idle();

    for (int i = 0; i < 21; i++) begin
      a_address = vecs[i].aa; a_data = vecs[i].ad; a_wren = vecs[i].aw; a_byteena = vecs[i].abe; a_rden = vecs[i].ar;
      b_address = vecs[i].ba; b_data = vecs[i].bd; b_wren = vecs[i].bw; b_byteena = vecs[i].bbe; b_rden = vecs[i].br;
      step();
      chk({vecs[i].name, ".aq"}, a_q, vecs[i].eaq);
      chk({vecs[i].name, ".aqv"}, {15'd0, a_qvalid}, {15'd0, vecs[i].eav});
      chk({vecs[i].name, ".bq"}, b_q, vecs[i].ebq);
      chk({vecs[i].name, ".bqv"}, {15'd0, b_qvalid}, {15'd0, vecs[i].ebv});
      chk({vecs[i].name, ".col"}, {15'd0, collision}, {15'd0, vecs[i].ecol});
    end

    // Write-first merge on the latency-2 instance, read-first on the other.
    idle_in();
    a_address = 4'd5; a_data = 16'h1234; a_wren = 1'b1; a_byteena = 2'b11;
    step();
    a_data = 16'hCD00; a_byteena = 2'b10; a_rden = 1'b1;
    step();
    chk("rdw0_aq", a_q, 16'h1234);
    chk("rdw1_qv_early", {15'd0, a_qvalid2}, 16'h0000);
    idle_in();
    step();
    chk("rdw1_aq2", a_q2, 16'hCD34);
    chk("rdw1_qv2", {15'd0, a_qvalid2}, 16'h0001);

    // Latency-2 back-to-back pipeline.
    a_address = 4'd1; a_data = 16'h0101; a_wren = 1'b1; a_byteena = 2'b11;
    b_address = 4'd2; b_data = 16'h0202; b_wren = 1'b1; b_byteena = 2'b11;
    step();
    idle_in();
    a_address = 4'd3; a_data = 16'h0303; a_wren = 1'b1; a_byteena = 2'b11;
    step();
    idle_in();
    for (int c = 0; c < 5; c++) begin
      a_rden = (c < 3);
      a_address = 4'(c + 1);
      step();
      chk($sformatf("lat2_qv_c%0d", c), {15'd0, a_qvalid2}, (c >= 1 && c <= 3) ? 16'h0001 : 16'h0000);
      if (c >= 1 && c <= 3) chk($sformatf("lat2_q_c%0d", c), a_q2, 16'h0101 * 16'(c));
    end

    // Reset with a read in flight and a write in the reset cycle.
    idle_in();
    a_address = 4'd1; a_rden = 1'b1;
    step();
    chk("rstflt_qv_c0", {15'd0, a_qvalid2}, 16'h0000);
    reset = 1'b1; a_address = 4'd2; a_wren = 1'b1; a_data = 16'hFFFF; a_byteena = 2'b11;
    a_address = 4'd1;
    step();
    chk("rstflt_qv_c1", {15'd0, a_qvalid2}, 16'h0000);
    reset = 1'b0;
    idle_in();
    step();
    chk("rstflt_qv_c2", {15'd0, a_qvalid2}, 16'h0000);
    chk("rstflt_aq", a_q, 16'h0000);
    chk("rstflt_aqv", {15'd0, a_qvalid}, 16'h0000);
    chk("rstflt_col", {15'd0, collision}, 16'h0000);
    wait_idle();
    chk("rstflt_qv_c3", {15'd0, a_qvalid2}, 16'h0000);
    a_address = 4'd1; a_rden = 1'b1;
    step();
    chk("rst_wr_blocked", a_q, POST_RST_1);
    chk("rst_wr_blocked_v", {15'd0, a_qvalid}, 16'h0001);
    idle_in();
    step();

`ifdef DPRAM_CLEAR_EN
    begin
      int n;
      int qv;
      reset = 1'b1;
      step();
      reset = 1'b0;
      a_address = 4'd3; a_rden = 1'b1;
      step();
      count_busy(40, n, qv);
      chk("clr_len", 16'(n), 16'd16);
      chk("clr_qv_busy", 16'(qv), 16'd0);
      idle_in();
      step();
      for (int i = 0; i < 16; i++) begin
        a_address = 4'(i); a_rden = 1'b1;
        step();
        chk($sformatf("clr_rd%0d", i), a_q, 16'h0000);
      end
      idle_in();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      count_busy(8, n, qv);
      reset = 1'b1;
      step();
      chk("clr_abort_busy", {15'd0, busy}, 16'h0000);
      reset = 1'b0;
      step();
      count_busy(40, n, qv);
      chk("clr_restart_len", 16'(n), 16'd16);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
Parametrised true dual-port synchronous RAM. It is the successor to the single-port word RAM.
- Two independent read/write ports (A, B) on one clock.
- Per-byte write enables, read-valid pipeline with selectable latency, selectable read-during-write mode, and a write-collision flag.
- Used as shared scratch/frame memory between the core and the video/DMA side.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH
ADDR_SPACE, 16, address bits; depth = 1 << ADDR_SPACE words
BYTE_WIDTH, 8, bits per byte lane; NB = DATA_WIDTH / BYTE_WIDTH
READ_LATENCY, 1, 1 or 2 clocks from rden sample to q/qvalid; any other value is a elaboration error
RDW_MODE, 0, same-port read-during-write: 0 = old data (read-first), 1 = new data (write-first, merged per byte)

Ports:
clock  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high
a_address  in  ADDR_SPACE  port A word address
a_data  in  DATA_WIDTH  port A write data
a_wren  in  1  port A write request
a_byteena  in  NB  port A byte lane enables; lane i = bits [i*BYTE_WIDTH +: BYTE_WIDTH]
a_rden  in  1  port A read request
a_q  out  DATA_WIDTH  port A read data
a_qvalid  out  1  a_q holds data for a request READ_LATENCY cycles earlier
b_address, b_data, b_wren, b_byteena, b_rden, b_q, b_qvalid  same as port A, for port B
collision  out  1  one-cycle pulse: both ports wrote the same address
busy  out  1  clear sequencer active; constant 0 unless DPRAM_CLEAR_EN

Behaviour:
- Reset values: a_q = b_q = 0; a_qvalid = b_qvalid = 0; collision = 0; all pipeline stages cleared. Memory contents are not cleared by reset (see optional feature).
- Reset is synchronous. In any cycle with reset = 1:
  - all writes and reads are suppressed;
  - in-flight reads are dropped and their qvalid never asserts.
- Write: on posedge with wren = 1, each lane i with byteena[i] = 1 is written; other lanes are untouched. wren = 1 with byteena = 0 is a no-op.
- Read: rden sampled at edge N.
  - READ_LATENCY = 1: q and qvalid update at edge N.
  - READ_LATENCY = 2: an extra output register stage; q and qvalid update at edge N+1.
  - Back-to-back reads give one result per cycle.
  - q holds its last value while qvalid = 0.
- Same-port read and write to the same address in one cycle:
  - RDW_MODE 0: returns the pre-write word.
  - RDW_MODE 1: returns the word with enabled lanes replaced by data and other lanes old.
- Cross-port read of an address written by the other port in the same cycle always returns old data, in both modes.
- Both ports write the same address in the same cycle:
  - per lane enabled on both ports, port A wins;
  - lanes enabled by only one port are written by that port;
  - collision = 1 on the following cycle only, if any lane overlapped; otherwise 0.
- Different addresses: fully independent; no stalls, no arbitration.

Optional Feature:
DPRAM_CLEAR_EN
- Defined:
  - Reset deassertion starts a clear sequencer. busy = 1 from the first cycle after reset falls.
  - An internal ADDR_SPACE-bit counter writes 0 to addresses 0 .. depth-1, one per cycle, through port A.
  - busy falls after exactly depth cycles.
  - While busy, all external wren/rden on both ports are ignored and qvalid stays 0.
  - Reset asserted mid-clear aborts the clear; it restarts from address 0 after reset deasserts.
  - busy = 0 during reset.
- Undefined:
  - busy is tied to 0.
  - No counter logic is present.
  - Memory powers up undefined.

Test Plan:
- Bench uses ADDR_SPACE = 4, DATA_WIDTH = 16, READ_LATENCY = 1, RDW_MODE = 0 unless stated.
- A writes 0xBEEF @3 (byteena = 11); next cycle B reads @3 -> b_q = 0xBEEF, b_qvalid = 1 on the edge after the read is sampled, and 0 the following cycle.
- Mem @5 = 0x1234; A writes 0xAB00 with byteena = 10 -> A reads 0xAB34. With RDW_MODE = 1, simultaneous A read+write @5 of 0xCDxx (byteena = 10) -> a_q = 0xCD34. With RDW_MODE = 0 -> a_q = 0x1234.
- A writes 0x1111 (byteena = 11) and B writes 0x2222 (byteena = 01), both @7, same cycle -> mem @7 = 0x1111, collision pulses high exactly one cycle. Repeat with A byteena = 10 -> mem @7 = 0x1122.
- READ_LATENCY = 2: rden on cycles 0, 1, 2 @1, @2, @3 -> qvalid high on cycles 2, 3, 4 with the matching data. Assert reset on cycle 1 -> no qvalid at all; a write issued in the reset cycle leaves memory unchanged.
- DPRAM_CLEAR_EN: preload nonzero values, pulse reset -> busy high for exactly 16 cycles. Reads issued while busy give no qvalid. After busy falls, all 16 addresses read 0. Reset at clear cycle 8 -> busy restarts and lasts a full 16 cycles.
